// File: rtl/diff_rr_scheduler.sv
// Round-robin shared differentiator: y = x - x_prev (mod 2^word_size) per channel.
// One combinational one-hot grant per cycle, one registered result port tagged
// with the channel index. Each channel keeps its own history register.
module diff_rr_scheduler #(
   parameter int word_size = 8,
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           req,
   input  logic [NUM_CH*word_size-1:0] data_in,
   input  logic [NUM_CH-1:0]           hold,
   input  logic [NUM_CH-1:0]           clear,
   output logic [NUM_CH-1:0]           ack,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CH_W-1:0]             out_ch,
   output logic [word_size-1:0]        data_out
);

   logic [word_size-1:0] hist [NUM_CH];
   logic [CH_W-1:0]      ptr;
   logic [CH_W-1:0]      g;
   logic [CH_W-1:0]      cand;
   logic                 grant;
   logic                 can_issue;
   logic [word_size-1:0] samp_g;
   logic [word_size-1:0] hist_g;
   logic [CH_W-1:0]      ptr_nxt;

   // The result slot frees up either when empty or when drained this cycle.
   assign can_issue = !out_valid || out_ready;

   // Round-robin scan starting at ptr; first requester found wins.
   always_comb begin
      grant = 1'b0;
      g     = '0;
      cand  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = CH_W'((int'(ptr) + k) % NUM_CH);
         if (!grant && req[cand]) begin
            grant = 1'b1;
            g     = cand;
         end
      end
      // Reset and back-pressure both suppress the grant; ack is never raised then.
      if (reset || !can_issue) begin
         grant = 1'b0;
      end
   end

   // One-hot acknowledge of the granted channel.
   always_comb begin
      ack = '0;
      if (grant) begin
         ack[g] = 1'b1;
      end
   end

   // Select the granted channel's sample and history for the shared subtractor.
   always_comb begin
      samp_g = '0;
      hist_g = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (CH_W'(i) == g) begin
            samp_g = data_in[i*word_size +: word_size];
            hist_g = hist[i];
         end
      end
   end

   // Pointer moves to the channel after the winner, wrapping at NUM_CH.
   assign ptr_nxt = (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;

   // Result register and round-robin pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         data_out  <= '0;
         ptr       <= '0;
      end else if (grant) begin
         out_valid <= 1'b1;
         out_ch    <= g;
         data_out  <= samp_g - hist_g;
         ptr       <= ptr_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Per-channel history; clear beats both the grant update and hold.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset || clear[i]) begin
            hist[i] <= '0;
         end else if (grant && (CH_W'(i) == g) && !hold[i]) begin
            hist[i] <= data_in[i*word_size +: word_size];
         end
      end
   end

endmodule

// File: tb/tb_diff_rr_scheduler.sv
// Directed bench for diff_rr_scheduler (4 channels, 8-bit words).
module tb_diff_rr_scheduler;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic [3:0]  hold;
   logic [3:0]  clear;
   logic [3:0]  ack;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ch;
   logic [7:0]  data_out;

   int n_cmp = 0;
   int n_err = 0;

   diff_rr_scheduler #(.word_size(8), .NUM_CH(4), .CH_W(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .data_in   (data_in),
      .hold      (hold),
      .clear     (clear),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .data_out  (data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_data(input int ch, input logic [7:0] v);
      data_in[ch*8 +: 8] = v;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      hold  = '0;
      clear = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'b1111; data_in = 32'h0403_0201;
      hold = '0; clear = '0; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack_forced: got %b want 0000", ack); end
      step();
      step();
      req = '0;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_ch !== 2'd0 || data_out !== 8'd0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b ch=%0d d=%0d want v=0 ch=0 d=0", out_valid, out_ch, data_out);
      end
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_idle_ack: got %b want 0000", ack); end
   endtask

   task automatic test_single_channel();
      do_reset();
      out_ready = 1'b1;
      req = 4'b0100; set_data(2, 8'd10);
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL single_ack1: got %b want 0100", ack); end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd2 || data_out !== 8'd10) begin
         n_err++;
         $display("FAIL single_res1: got v=%b ch=%0d d=%0d want v=1 ch=2 d=10", out_valid, out_ch, data_out);
      end
      set_data(2, 8'd25);
      #1;
      n_cmp++;
      if (ack !== 4'b0100) begin n_err++; $display("FAIL single_ack2: got %b want 0100", ack); end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd2 || data_out !== 8'd15) begin
         n_err++;
         $display("FAIL single_res2: got v=%b ch=%0d d=%0d want v=1 ch=2 d=15", out_valid, out_ch, data_out);
      end
      req = '0;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || data_out !== 8'd15) begin
         n_err++;
         $display("FAIL single_drain: got v=%b d=%0d want v=0 d=15", out_valid, data_out);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ack;
      logic [7:0] exp_d;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_data(i, 8'(i*10 + 5));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_ack = 4'b0001 << (k % 4);
         exp_d   = (k < 4) ? 8'(k*10 + 5) : 8'd0;
         #1;
         n_cmp++;
         if (ack !== exp_ack) begin n_err++; $display("FAIL rr_ack[%0d]: got %b want %b", k, ack, exp_ack); end
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || data_out !== exp_d) begin
            n_err++;
            $display("FAIL rr_res[%0d]: got v=%b ch=%0d d=%0d want v=1 ch=%0d d=%0d",
                     k, out_valid, out_ch, data_out, k % 4, exp_d);
         end
      end
   endtask

   // Continues from test_round_robin: result (ch0, 0) pending, ptr=1, req all high.
   task automatic test_back_pressure();
      out_ready = 1'b0;
      set_data(1, 8'd40);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (ack !== 4'b0000) begin n_err++; $display("FAIL bp_ack[%0d]: got %b want 0000", k, ack); end
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || out_ch !== 2'd0 || data_out !== 8'd0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%0d want v=1 ch=0 d=0", k, out_valid, out_ch, data_out);
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (ack !== 4'b0010) begin n_err++; $display("FAIL bp_resume_ack: got %b want 0010", ack); end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || data_out !== 8'd25) begin
         n_err++;
         $display("FAIL bp_resume_res: got v=%b ch=%0d d=%0d want v=1 ch=1 d=25", out_valid, out_ch, data_out);
      end
      req = '0;
      step();
   endtask

   task automatic test_wrap();
      logic [7:0] samp [4];
      logic [7:0] expd [4];
      samp[0] = 8'd250; expd[0] = 8'd250;
      samp[1] = 8'd5;   expd[1] = 8'd11;
      samp[2] = 8'd1;   expd[2] = 8'd252;
      samp[3] = 8'd0;   expd[3] = 8'd255;
      do_reset();
      out_ready = 1'b1;
      req = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         set_data(0, samp[k]);
         #1;
         n_cmp++;
         if (ack !== 4'b0001) begin n_err++; $display("FAIL wrap_ack[%0d]: got %b want 0001", k, ack); end
         step();
         n_cmp++;
         if (out_ch !== 2'd0 || data_out !== expd[k]) begin
            n_err++;
            $display("FAIL wrap_res[%0d]: got ch=%0d d=%0d want ch=0 d=%0d", k, out_ch, data_out, expd[k]);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_hold_clear();
      logic [7:0] samp [5];
      logic [7:0] expd [5];
      logic       hv   [5];
      logic       cv   [5];
      samp[0] = 8'd30; expd[0] = 8'd30; hv[0] = 1'b0; cv[0] = 1'b0;
      samp[1] = 8'd40; expd[1] = 8'd10; hv[1] = 1'b1; cv[1] = 1'b0;
      samp[2] = 8'd50; expd[2] = 8'd20; hv[2] = 1'b1; cv[2] = 1'b0;
      samp[3] = 8'd60; expd[3] = 8'd30; hv[3] = 1'b1; cv[3] = 1'b1;
      samp[4] = 8'd8;  expd[4] = 8'd8;  hv[4] = 1'b0; cv[4] = 1'b0;
      do_reset();
      out_ready = 1'b1;
      req = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         set_data(1, samp[k]);
         hold[1]  = hv[k];
         clear[1] = cv[k];
         #1;
         n_cmp++;
         if (ack !== 4'b0010) begin n_err++; $display("FAIL hc_ack[%0d]: got %b want 0010", k, ack); end
         step();
         n_cmp++;
         if (out_ch !== 2'd1 || data_out !== expd[k]) begin
            n_err++;
            $display("FAIL hc_res[%0d]: got ch=%0d d=%0d want ch=1 d=%0d", k, out_ch, data_out, expd[k]);
         end
      end
      req = '0; hold = '0; clear = '0;
      step();
   endtask

   task automatic test_mid_reset();
      do_reset();
      out_ready = 1'b1;
      req = 4'b1000; set_data(3, 8'd100);
      step();
      req = 4'b0010; set_data(1, 8'd3);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || data_out !== 8'd3) begin
         n_err++;
         $display("FAIL mr_setup: got v=%b ch=%0d d=%0d want v=1 ch=1 d=3", out_valid, out_ch, data_out);
      end
      out_ready = 1'b0;
      reset = 1'b1;
      req = 4'b1000; set_data(3, 8'd7);
      #1;
      n_cmp++;
      if (ack !== 4'b0000) begin n_err++; $display("FAIL mr_ack_in_reset: got %b want 0000", ack); end
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_ch !== 2'd0 || data_out !== 8'd0) begin
         n_err++;
         $display("FAIL mr_dropped: got v=%b ch=%0d d=%0d want v=0 ch=0 d=0", out_valid, out_ch, data_out);
      end
      reset = 1'b0;
      out_ready = 1'b1;
      req = 4'b1010;
      #1;
      n_cmp++;
      if (ack !== 4'b0010) begin n_err++; $display("FAIL mr_ptr_zero: got %b want 0010", ack); end
      step();
      n_cmp++;
      if (out_ch !== 2'd1 || data_out !== 8'd3) begin
         n_err++;
         $display("FAIL mr_ch1: got ch=%0d d=%0d want ch=1 d=3", out_ch, data_out);
      end
      req = 4'b1000;
      #1;
      n_cmp++;
      if (ack !== 4'b1000) begin n_err++; $display("FAIL mr_ack3: got %b want 1000", ack); end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || data_out !== 8'd7) begin
         n_err++;
         $display("FAIL mr_ch3: got v=%b ch=%0d d=%0d want v=1 ch=3 d=7", out_valid, out_ch, data_out);
      end
      req = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_round_robin();
      test_back_pressure();
      test_wrap();
      test_hold_clear();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
